// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access in flight; reads that never see mem_rvalid complete with err after TIMEOUT cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [1:0]              we,
    input  logic [2*ADDR_WIDTH-1:0] addr,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    output logic [1:0]              gnt,
    output logic [1:0]              done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic                    busy,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rvalid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  win;
    logic [1:0]            owner_hot;

    assign owner_hot = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt         = '0;
        win         = ptr_q;

        case (state_q)
            IDLE: begin
                // Grant is gated by rst so it stays low for the whole reset window.
                if (rst && (req != 2'b00)) begin
                    win         = (req == 2'b11) ? ptr_q : req[1];
                    gnt         = win ? 2'b10 : 2'b01;
                    ptr_d       = ~win;
                    owner_d     = win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[win];
                    mem_addr_d  = win ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
                    mem_wdata_d = win ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    done_d  = owner_hot;
                    state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    done_d  = owner_hot;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = CW'(TIMEOUT);
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = owner_hot;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
